// File: rtl/xor_share_ctrl_if.sv
// rtl/xor_share_ctrl_if.sv - requester, response and engine bus of the shared XOR controller
interface xor_share_ctrl_if #(
    parameter int NREQ = 4,
    parameter int W    = 8
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [W-1:0]      rsp_data;
    logic              rsp_err;
    logic [W-1:0]      eng_a;
    logic [W-1:0]      eng_b;
    logic              eng_start;
    logic [W-1:0]      eng_out;
    logic              eng_done;
    logic              busy;

    // master: requesters plus engine; slave: the controller
    modport master (
        output req_valid, req_a, req_b, rsp_ready, eng_out, eng_done,
        input  req_ready, rsp_valid, rsp_data, rsp_err, eng_a, eng_b, eng_start, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, eng_out, eng_done,
        output req_ready, rsp_valid, rsp_data, rsp_err, eng_a, eng_b, eng_start, busy
    );
endinterface

// File: rtl/xor_share_ctrl.sv
// rtl/xor_share_ctrl.sv - round-robin sharing of one XOR engine among NREQ requesters
module xor_share_ctrl #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int TMO  = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    xor_share_ctrl_if.slave bus
);
    localparam int              PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0]      TMO_LAST = 8'(TMO - 1);
    localparam logic [NREQ-1:0] ONE      = NREQ'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [PW-1:0] winner;
    logic          found;
    logic [PW-1:0] owner_inc;
    logic [7:0]    tmo_cnt;
    logic [W-1:0]  eng_a_q;
    logic [W-1:0]  eng_b_q;
    logic [W-1:0]  rsp_data_q;
    logic          rsp_err_q;

    // Walk downwards so the lowest offset from ptr is the last, winning, assignment.
    always_comb begin
        int idx;
        winner = ptr;
        found  = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (bus.req_valid[idx]) begin
                winner = PW'(idx);
                found  = 1'b1;
            end
        end
    end

    assign owner_inc = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (found) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (bus.eng_done || tmo_cnt == TMO_LAST) state_nxt = RESP;
            RESP:    if (bus.rsp_ready[owner]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            tmo_cnt    <= '0;
            eng_a_q    <= '0;
            eng_b_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        owner   <= winner;
                        eng_a_q <= bus.req_a[int'(winner)*W +: W];
                        eng_b_q <= bus.req_b[int'(winner)*W +: W];
                    end
                end
                START: tmo_cnt <= '0;
                WAIT: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    // A done pulse landing on the last timeout cycle still counts as success.
                    if (bus.eng_done) begin
                        rsp_data_q <= bus.eng_out;
                        rsp_err_q  <= 1'b0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready[owner]) begin
                        ptr       <= owner_inc;
                        rsp_err_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // req_ready is combinational, so it is masked by rst_n to stay quiet during reset.
    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        if (state == IDLE && found && rst_n) bus.req_ready = ONE << winner;
        if (state == RESP) bus.rsp_valid = ONE << owner;
    end

    assign bus.eng_start = (state == START);
    assign bus.busy      = (state != IDLE);
    assign bus.eng_a     = eng_a_q;
    assign bus.eng_b     = eng_b_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule
